// File: rtl/pll_ctrl_pkg.sv
// Shared constants for the PLL lock supervisor: state encoding and status counter widths.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;
  localparam int RETRY_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_RESET_PLL  = 3'd0;
  localparam state_t ST_WAIT_LOCK  = 3'd1;
  localparam state_t ST_STABLE_CHK = 3'd2;
  localparam state_t ST_RUN        = 3'd3;
  localparam state_t ST_FAULT      = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_sync_p0;
  logic r_sync_p1;

  // first flop may go metastable, second gives it a full cycle to resolve
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_d;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign o_q = r_sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: reset pulse, lock wait with timeout/retry, lock qualification,
// downstream reset release and in-run lock supervision. Clocked by the board reference clock.
module pll_lock_supervisor
  import pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock_i,
  input  logic               relock_req_i,
  output logic               pll_rst_o,
  output logic               sys_rst_o,
  output logic               locked_o,
  output logic               fault_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [LOSS_W-1:0]  loss_cnt_o
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // lock-loss counter sticks at all-ones instead of wrapping
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  localparam int CNT_W = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic               w_lock_s;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic [LOSS_W-1:0]  r_loss;
  logic               r_pll_rst;
  logic               r_sys_rst;
  logic               r_locked;
  logic               r_fault;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [LOSS_W-1:0]  w_loss_nxt;
  logic               w_cnt_inc;
  logic               w_restart;
  logic               w_pll_rst_nxt;
  logic               w_sys_rst_nxt;
  logic               w_locked_nxt;
  logic               w_fault_nxt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock_i),
    .o_q (w_lock_s)
  );

  // state, shared counter, status counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_locked  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_locked  <= w_locked_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  // next state: relock request first, then lock loss, then counter expiry
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_cnt_inc   = 1'b0;
    w_restart   = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (relock_req_i) begin
      w_state_nxt = ST_RESET_PLL;
      w_retry_nxt = '0;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_cnt == HOLD_LAST) w_state_nxt = ST_WAIT_LOCK;
          else                    w_cnt_inc   = 1'b1;
        end
        ST_WAIT_LOCK: begin
          // a lock arriving on the expiry cycle still wins
          if (w_lock_s) begin
            w_state_nxt = ST_STABLE_CHK;
          end else if (r_cnt == TIMEOUT_LAST) begin
            if (r_retry < RETRY_LIMIT) begin
              w_retry_nxt = r_retry + 1'b1;
              w_state_nxt = ST_RESET_PLL;
            end else begin
              w_state_nxt = ST_FAULT;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_STABLE_CHK: begin
          if (!w_lock_s)                w_state_nxt = ST_WAIT_LOCK;
          else if (r_cnt == STABLE_LAST) w_state_nxt = ST_RUN;
          else                          w_cnt_inc   = 1'b1;
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_loss_nxt  = sat_inc(r_loss);
            w_retry_nxt = '0;
            w_state_nxt = ST_RESET_PLL;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RESET_PLL;
        end
      endcase
    end
    // counter restarts on every state entry, including a relock that stays in RESET_PLL
    if (w_restart || (w_state_nxt != r_state)) w_cnt_nxt = '0;
    else if (w_cnt_inc)                        w_cnt_nxt = r_cnt + 1'b1;
  end

  // output decode from the upcoming state so the flags register alongside it
  always_comb begin
    w_pll_rst_nxt = (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
    w_sys_rst_nxt = (w_state_nxt != ST_RUN);
    w_locked_nxt  = (w_state_nxt == ST_RUN);
    w_fault_nxt   = (w_state_nxt == ST_FAULT);
  end

  assign pll_rst_o   = r_pll_rst;
  assign sys_rst_o   = r_sys_rst;
  assign locked_o    = r_locked;
  assign fault_o     = r_fault;
  assign retry_cnt_o = r_retry;
  assign loss_cnt_o  = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed sequences plus randomized lock/request/reset
// traffic, all compared cycle by cycle against a phase/timer reference model.
module tb_pll_lock_supervisor;

  localparam int RST_HOLD    = 4;
  localparam int TIMEOUT     = 20;
  localparam int STABLE      = 8;
  localparam int MAX_RETRIES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock_i;
  logic       relock_req_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES    (RST_HOLD),
    .LOCK_TIMEOUT       (TIMEOUT),
    .LOCK_STABLE_CYCLES (STABLE),
    .MAX_RETRIES        (MAX_RETRIES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock_i   (pll_lock_i),
    .relock_req_i (relock_req_i),
    .pll_rst_o    (pll_rst_o),
    .sys_rst_o    (sys_rst_o),
    .locked_o     (locked_o),
    .fault_o      (fault_o),
    .retry_cnt_o  (retry_cnt_o),
    .loss_cnt_o   (loss_cnt_o)
  );

  // ---------------- reference model ----------------
  typedef enum {PH_HOLD, PH_ACQUIRE, PH_QUALIFY, PH_LOCKED, PH_DEAD} phase_e;

  phase_e m_ph   = PH_HOLD;
  int     m_time = 0;   // cycles already spent counting in the current phase
  int     m_retry = 0;
  int     m_loss  = 0;
  bit [1:0] m_sync = 2'b00;  // lock input as it travels through the two sync flops

  task automatic enter_phase(input phase_e p);
    m_ph   = p;
    m_time = 0;
  endtask

  task automatic model_step(input bit r, input bit req, input bit lk);
    bit ls;
    if (r) begin
      enter_phase(PH_HOLD);
      m_retry = 0;
      m_loss  = 0;
      m_sync  = 2'b00;
      return;
    end
    ls     = m_sync[1];
    m_sync = {m_sync[0], lk};
    if (req) begin
      enter_phase(PH_HOLD);
      m_retry = 0;
      return;
    end
    case (m_ph)
      PH_HOLD: begin
        m_time++;
        if (m_time == RST_HOLD) enter_phase(PH_ACQUIRE);
      end
      PH_ACQUIRE: begin
        if (ls) enter_phase(PH_QUALIFY);
        else begin
          m_time++;
          if (m_time == TIMEOUT) begin
            if (m_retry < MAX_RETRIES) begin
              m_retry++;
              enter_phase(PH_HOLD);
            end else begin
              enter_phase(PH_DEAD);
            end
          end
        end
      end
      PH_QUALIFY: begin
        if (!ls) enter_phase(PH_ACQUIRE);
        else begin
          m_time++;
          if (m_time == STABLE) enter_phase(PH_LOCKED);
        end
      end
      PH_LOCKED: begin
        if (!ls) begin
          if (m_loss < 255) m_loss++;
          m_retry = 0;
          enter_phase(PH_HOLD);
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // drive one cycle's inputs, advance model on the edge, compare on the falling edge
  task automatic cycle(input bit r, input bit req, input bit lk);
    rst          = r;
    relock_req_i = req;
    pll_lock_i   = lk;
    @(posedge clk);
    model_step(r, req, lk);
    @(negedge clk);
    chk("pll_rst", int'(pll_rst_o), int'(m_ph == PH_HOLD || m_ph == PH_DEAD));
    chk("sys_rst", int'(sys_rst_o), int'(m_ph != PH_LOCKED));
    chk("locked",  int'(locked_o),  int'(m_ph == PH_LOCKED));
    chk("fault",   int'(fault_o),   int'(m_ph == PH_DEAD));
    chk("retry",   int'(retry_cnt_o), m_retry);
    chk("loss",    int'(loss_cnt_o),  m_loss);
  endtask

  // hold lock high until locked_o, returning the number of cycles taken
  task automatic wait_locked(input int budget, output int n);
    n = 0;
    while (!locked_o && n < budget) begin
      cycle(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (!locked_o) chk("lock_wait_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    int  hi_cnt;
    int  mism;
    int  lat_err;
    bit  lvl;
    bit  r;
    bit  req;

    // reset state
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    chk("rst_pll_rst", int'(pll_rst_o), 1);
    chk("rst_sys_rst", int'(sys_rst_o), 1);
    chk("rst_loss",    int'(loss_cnt_o), 0);

    // 1: normal bring-up, lock raised 10 cycles after release
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      hi_cnt += int'(pll_rst_o);
      cycle(1'b0, 1'b0, 1'b0);
    end
    chk("s1_pll_rst_len", hi_cnt, RST_HOLD);
    wait_locked(60, n);
    // two sync flops, one WAIT_LOCK->STABLE_CHK edge, then the qualification window
    chk("s1_lock_to_run", n, 2 + 1 + STABLE);
    chk("s1_retry", int'(retry_cnt_o), 0);

    // 2: no lock at all -> three reset pulses, then FAULT
    mism = 0;
    cycle(1'b0, 1'b1, 1'b0);
    if (pll_rst_o !== 1'b1) mism++;
    for (int i = 1; i <= 72; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (i < 72) begin
        if (pll_rst_o !== ((i % (RST_HOLD + TIMEOUT)) < RST_HOLD)) mism++;
      end
      if (i == 24) chk("s2_retry_1", int'(retry_cnt_o), 1);
      if (i == 48) chk("s2_retry_2", int'(retry_cnt_o), 2);
      if (i == 71) chk("s2_no_fault_yet", int'(fault_o), 0);
      if (i == 72) chk("s2_fault", int'(fault_o), 1);
    end
    chk("s2_pulse_pattern", mism, 0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    chk("s2_fault_held", int'(fault_o), 1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("s2_relock_fault", int'(fault_o), 0);
    chk("s2_relock_retry", int'(retry_cnt_o), 0);
    chk("s2_relock_pll_rst", int'(pll_rst_o), 1);

    // 3: lock glitch after 5 stable cycles in STABLE_CHK
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    hi_cnt = 0;
    repeat (6) begin
      cycle(1'b0, 1'b0, 1'b1);
      hi_cnt += int'(!sys_rst_o);
    end
    repeat (2) begin
      cycle(1'b0, 1'b0, 1'b0);
      hi_cnt += int'(!sys_rst_o);
    end
    chk("s3_no_release_on_glitch", hi_cnt, 0);
    wait_locked(60, n);
    chk("s3_fresh_qualify", n, 2 + 1 + STABLE);

    // 4: repeated lock loss in RUN, latency and saturation
    lat_err = 0;
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (sys_rst_o !== 1'b0) lat_err++;
      cycle(1'b0, 1'b0, 1'b0);
      if (sys_rst_o !== 1'b0) lat_err++;
      cycle(1'b0, 1'b0, 1'b0);
      if (sys_rst_o !== 1'b1 || pll_rst_o !== 1'b1) lat_err++;
      if (k == 0) chk("s4_loss_first", int'(loss_cnt_o), 1);
      wait_locked(80, n);
    end
    chk("s4_latency_errs", lat_err, 0);
    chk("s4_loss_sat", int'(loss_cnt_o), 255);

    // 5: rst mid-sequence with one retry used, then relock from RUN
    cycle(1'b0, 1'b1, 1'b0);
    repeat (33) cycle(1'b0, 1'b0, 1'b0);
    chk("s5_retry_before_rst", int'(retry_cnt_o), 1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("s5_rst_pll_rst", int'(pll_rst_o), 1);
    chk("s5_rst_sys_rst", int'(sys_rst_o), 1);
    chk("s5_rst_locked",  int'(locked_o), 0);
    chk("s5_rst_fault",   int'(fault_o), 0);
    chk("s5_rst_retry",   int'(retry_cnt_o), 0);
    chk("s5_rst_loss",    int'(loss_cnt_o), 0);
    wait_locked(60, n);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    wait_locked(80, n);
    chk("s5_loss_one", int'(loss_cnt_o), 1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("s5_relock_locked", int'(locked_o), 0);
    chk("s5_relock_pll_rst", int'(pll_rst_o), 1);
    chk("s5_relock_loss", int'(loss_cnt_o), 1);
    wait_locked(60, n);

    // randomized traffic: lock level with occasional flips, sparse requests and resets
    lvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29, 0) == 0) lvl = ~lvl;
      r   = ($urandom_range(699, 0) == 0);
      req = ($urandom_range(249, 0) == 0);
      cycle(r, req, lvl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
